pipeline_hazard_ctrl: RTL

Central sequencer for the five-stage pipeline. Every cycle it decides whether each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC advance, hold or take a bubble. It resolves memory waits, EX-stage redirects, load-use hazards, instruction-fetch misses and halt draining. It also keeps saturating stall and flush event counters for the performance registers.

---
 rtl/pipeline_hazard_ctrl_if.sv | 49 ++++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: hazard sources in, per-latch controls and counters out.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned REG_W = 5;

   // hazard sources
   logic             ihit;
   logic             dhit;
   logic [REG_W-1:0] ifid_rs;
   logic [REG_W-1:0] ifid_rt;
   logic             ifid_uses_rt;
   logic             idex_dREN;
   logic [REG_W-1:0] idex_RW;
   logic             exmem_dREN;
   logic             exmem_dWEN;
   logic             ex_redirect;
   logic             memwb_halt;

   // pipeline controls
   logic             pc_en;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_stall;
   logic             idex_flush;
   logic             exmem_stall;
   logic             exmem_flush;
   logic             memwb_stall;
   logic             memwb_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_RW,
             exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
      input  pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, exmem_flush, memwb_stall, memwb_flush,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dREN, idex_RW,
             exmem_dREN, exmem_dWEN, ex_redirect, memwb_halt,
      output pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
             exmem_stall, exmem_flush, memwb_stall, memwb_flush,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: per-latch stall/flush, PC enable, halt drain,
// and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input logic                    CLK,
   input logic                    nRST,
   pipeline_hazard_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   logic dwait;
   logic lu;
   logic pc_en_c;
   logic ifid_stall_c, ifid_flush_c;
   logic idex_stall_c, idex_flush_c;
   logic exmem_stall_c, exmem_flush_c;
   logic memwb_stall_c, memwb_flush_c;
   logic redirect_accept_c;
   logic stall_event_c;

   // Hazard conditions: outstanding data access and load-use dependency
   always_comb begin
      dwait = (bus.exmem_dREN | bus.exmem_dWEN) & ~bus.dhit;
      lu    = bus.idex_dREN & (bus.idex_RW != '0) &
              ((bus.idex_RW == bus.ifid_rs) |
               (bus.ifid_uses_rt & (bus.idex_RW == bus.ifid_rt)));
   end

   // Priority-ordered latch controls; DWAIT with dhit=1 evaluates like RUN
   always_comb begin
      pc_en_c           = 1'b0;
      ifid_stall_c      = 1'b0;
      ifid_flush_c      = 1'b0;
      idex_stall_c      = 1'b0;
      idex_flush_c      = 1'b0;
      exmem_stall_c     = 1'b0;
      exmem_flush_c     = 1'b0;
      memwb_stall_c     = 1'b0;
      memwb_flush_c     = 1'b0;
      redirect_accept_c = 1'b0;

      if (state == HALTED || bus.memwb_halt) begin
         ifid_stall_c  = 1'b1;
         idex_stall_c  = 1'b1;
         exmem_stall_c = 1'b1;
         memwb_stall_c = 1'b1;
      end else if (dwait) begin
         // branch in EX stays put and is re-evaluated after the wait
         ifid_stall_c  = 1'b1;
         idex_stall_c  = 1'b1;
         exmem_stall_c = 1'b1;
         memwb_flush_c = 1'b1;
      end else if (bus.ex_redirect) begin
         ifid_flush_c      = 1'b1;
         idex_flush_c      = 1'b1;
         pc_en_c           = 1'b1;
         redirect_accept_c = 1'b1;
      end else if (lu || !bus.ihit) begin
         ifid_stall_c = 1'b1;
         idex_flush_c = 1'b1;
      end else begin
         pc_en_c = 1'b1;
      end

      stall_event_c = ~pc_en_c & (state != HALTED);
   end

   // State and saturating event counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (state == HALTED || bus.memwb_halt) begin
            state <= HALTED;
         end else if (dwait) begin
            state <= DWAIT;
         end else begin
            state <= RUN;
         end

         if (stall_event_c && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (redirect_accept_c && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   // Drive the bus
   assign bus.pc_en       = pc_en_c;
   assign bus.ifid_stall  = ifid_stall_c;
   assign bus.ifid_flush  = ifid_flush_c;
   assign bus.idex_stall  = idex_stall_c;
   assign bus.idex_flush  = idex_flush_c;
   assign bus.exmem_stall = exmem_stall_c;
   assign bus.exmem_flush = exmem_flush_c;
   assign bus.memwb_stall = memwb_stall_c;
   assign bus.memwb_flush = memwb_flush_c;
   assign bus.halted      = (state == HALTED);
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;
endmodule
